// File: rtl/snake_uart_tx.sv
// Byte-wide UART transmitter with a small write FIFO, sending 8N1 frames LSB first.
// Define SNAKE_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module snake_uart_tx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] dataTX,
    input  logic       WR_TX,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       TX
);
    localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

`ifdef SNAKE_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx, tx_n;
`ifdef SNAKE_UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    // full comes from the registered count, so a write seen while full is
    // dropped even if the FSM pops in that same cycle.
    assign full     = (count == CNT_FULL);
    assign push     = WR_TX & ~full;
    assign busy     = (state != IDLE) | (count != '0);
    assign TX       = tx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (WR_TX && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dataTX;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef SNAKE_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
`ifdef SNAKE_UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef SNAKE_UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef SNAKE_UART_TX_PARITY_EN
                        tx_n    = par;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        idx_n   = bit_idx + 3'd1;
                        tx_n    = shift[1];
                    end
                end
            end
`ifdef SNAKE_UART_TX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    // back-to-back frames: go straight to a new start bit
                    if (count != '0) begin
                        pop     = 1'b1;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
        if (pop) begin
            shift_n = mem[rd_ptr];
`ifdef SNAKE_UART_TX_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
        end
    end
endmodule

// File: tb/tb_snake_uart_tx.sv
// Bench for snake_uart_tx: frame-offset reference model, serial decoder and directed/random stimulus.
module tb_snake_uart_tx;
    localparam int CLK_FREQ = 25000000;
    localparam int BAUD     = 115200;
    localparam int FD       = 4;
    localparam int BD       = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int BD2      = (CLK_FREQ + 9600 / 2) / 9600;
`ifdef SNAKE_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR = NB * BD;

    logic       clk = 1'b0;
    logic       rstn, WR_TX, full, busy, overflow, TX;
    logic [7:0] dataTX;
    logic       w2, full2, busy2, ovf2, tx2;
    logic [7:0] d2;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #20 clk = ~clk;

    snake_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn), .dataTX(dataTX), .WR_TX(WR_TX),
        .full(full), .busy(busy), .overflow(overflow), .TX(TX));

    snake_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(9600), .FIFO_DEPTH(FD)) dut2 (
        .clk(clk), .rstn(rstn), .dataTX(d2), .WR_TX(w2),
        .full(full2), .busy(busy2), .overflow(ovf2), .TX(tx2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the offset into the current frame.
    byte unsigned mq[$];
    logic       m_act = 1'b0;
    logic [7:0] m_byte = '0;
    int         m_off = 0;
    logic       m_ovf = 1'b0;
    int         m_sz;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_act = 1'b0;
            m_off = 0;
            m_ovf = 1'b0;
        end else begin
            m_sz = mq.size();
            if (m_act) begin
                m_off++;
                if (m_off == FR) m_act = 1'b0;
            end
            if (!m_act && m_sz > 0) begin
                m_byte = mq.pop_front();
                m_act  = 1'b1;
                m_off  = 0;
            end
            if (WR_TX) begin
                if (m_sz == FD) m_ovf = 1'b1;
                else            mq.push_back(dataTX);
            end
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_off / BD;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        if (k == 9 && NB == 11) return ^m_byte;
        return 1'b1;
    endfunction

    logic [3:0] exp_o;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_o = {exp_tx(), (m_act || mq.size() != 0), (mq.size() == FD), m_ovf};
            chk("outs", {28'd0, TX, busy, full, overflow}, {28'd0, exp_o});
        end
    end

    // Serial decoder sampling mid-bit, independent of the model.
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    int         rx_k;
    logic [7:0] rx_sh = '0;
    byte unsigned rx_q[$];
    always @(negedge clk) begin
        if (!rstn) rx_on = 1'b0;
        else if (!rx_on) begin
            if (TX == 1'b0) begin rx_on = 1'b1; rx_cnt = 0; end
        end else rx_cnt++;
        if (rx_on && (rx_cnt % BD) == BD / 2) begin
            rx_k = rx_cnt / BD;
            if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k-1] = TX;
            if (rx_k == NB - 1) begin rx_q.push_back(rx_sh); rx_on = 1'b0; end
        end
    end

    task automatic wait_idle(input int lim, input string nm);
        int t = 0;
        while ((busy || TX == 1'b0) && t < lim) begin @(negedge clk); t++; end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_rx(input string nm, input int idx, input logic [7:0] exp);
        chk(nm, (rx_q.size() > idx) ? {24'd0, rx_q[idx]} : 32'hFFFF, {24'd0, exp});
    endtask

    logic [7:0] seq4 [4];
    int f, w;

    initial begin
        seq4[0] = 8'h43; seq4[1] = 8'h44; seq4[2] = 8'h41; seq4[3] = 8'h42;
        rstn = 1'b0; WR_TX = 1'b0; dataTX = '0; w2 = 1'b0; d2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", TX, 1); chk("rst_busy", busy, 0);
        chk("rst_full", full, 0); chk("rst_ovf", overflow, 0);
        chk_en = 1'b1;
        rstn = 1'b1;
        repeat (5000) @(negedge clk);
        chk("idle_tx", TX, 1); chk("idle_busy", busy, 0);

        // single byte 0x41
        rx_q.delete();
        WR_TX = 1'b1; dataTX = 8'h41;
        @(negedge clk); WR_TX = 1'b0;
        chk("b41_lat", TX, 1);
        @(negedge clk);
        chk("b41_start0", TX, 0);
        repeat (BD - 1) @(negedge clk); chk("b41_startend", TX, 0);
        @(negedge clk);                 chk("b41_bit0", TX, 1);
        repeat (BD) @(negedge clk);     chk("b41_bit1", TX, 0);
        repeat (5 * BD) @(negedge clk); chk("b41_bit6", TX, 1);
        repeat (2 * BD) @(negedge clk); chk("b41_bit9", TX, (NB == 11) ? 0 : 1);
        repeat (FR - 1 - 9 * BD) @(negedge clk); chk("b41_busy_last", busy, 1);
        @(negedge clk); chk("b41_busy_fall", busy, 0);
        chk("b41_rxn", rx_q.size(), 1);
        chk_rx("b41_rx", 0, 8'h41);

        // four consecutive writes -> four back-to-back frames
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            WR_TX = 1'b1; dataTX = seq4[i];
            @(negedge clk);
        end
        WR_TX = 1'b0;
        repeat (FR - 2) @(negedge clk); chk("b4_nogap", TX, 0);
        repeat (3 * FR - 1) @(negedge clk); chk("b4_busy_last", busy, 1);
        @(negedge clk); chk("b4_busy_fall", busy, 0);
        chk("b4_rxn", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_rx("b4_rx", i, seq4[i]);

        // overflow: five writes while 0xAA is on the line
        rx_q.delete();
        WR_TX = 1'b1; dataTX = 8'hAA;
        @(negedge clk); WR_TX = 1'b0;
        repeat (2 * BD) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            WR_TX = 1'b1; dataTX = 8'(i + 1);
            @(negedge clk);
        end
        WR_TX = 1'b0;
        chk("ovf_full", full, 1); chk("ovf_set", overflow, 1);
        wait_idle(6 * FR, "ovf_idle");
        chk("ovf_sticky", overflow, 1);
        chk("ovf_rxn", rx_q.size(), 5);
        chk_rx("ovf_rx0", 0, 8'hAA);
        for (int i = 1; i < 5; i++) chk_rx("ovf_rx", i, 8'(i));

        // random writes
        repeat (15000) begin
            WR_TX = ($urandom_range(0, 399) == 0);
            dataTX = 8'($urandom);
            @(negedge clk);
        end
        WR_TX = 1'b0;
        wait_idle(6 * FR, "rnd_idle");

        // reset during bit 3 of 0x55 with two bytes queued
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            WR_TX = 1'b1; dataTX = (i == 0) ? 8'h55 : 8'(8'h12 + i);
            @(negedge clk);
        end
        WR_TX = 1'b0;
        repeat (4 * BD + 49) @(negedge clk);
        chk("mid_busy", busy, 1);
        #5 rstn = 1'b0;
        #1 chk("mid_tx", TX, 1); chk("mid_busy0", busy, 0);
        chk("mid_full", full, 0); chk("mid_ovf", overflow, 0);
        @(negedge clk);
        #5 rstn = 1'b1;
        repeat (3 * FR) @(negedge clk);
        chk("mid_rxn", rx_q.size(), 0);
        chk("mid_tx_idle", TX, 1); chk("mid_busy_idle", busy, 0);

        // 9600 baud instance: start-bit and frame widths
        w2 = 1'b1; d2 = 8'hA5;
        @(negedge clk); w2 = 1'b0;
        f = 0;
        while (tx2 && f < 10) begin @(negedge clk); f++; end
        chk("b96_lat", f, 1);
        f = 0; w = 0;
        while (busy2 && f < NB * BD2 + 100) begin
            if (!tx2 && w == f) w = f + 1;
            f++;
            @(negedge clk);
        end
        chk("b96_start_w", w, BD2);
        chk("b96_frame_w", f, NB * BD2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
